nrzi_destuff: RTL and testbench
===============================

NRZI_DESTUFF -- requirements
Module: nrzi_destuff

Interface
REQ-001 Parameter STUFF_LEN, default 6, number of consecutive decoded 1s after which the transmitter inserts a 0; legal range 2..15.
REQ-002 Parameter EOP_LEN, default 2, number of consecutive SE0 samples that constitute an end-of-packet; legal range 1..7.
REQ-003 Parameter IDLE_LEVEL, default 1'b1, d_plus level of the idle (J) line state; NRZI history resets to this value.
REQ-004 Port clk  input  1  system clock, all state updates on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port d_plus  input  1  synchronised D+ line level.
REQ-007 Port d_minus  input  1  synchronised D- line level.
REQ-008 Port shift_enable  input  1  sample strobe, one clk cycle wide, marks a bit-centre sample.
REQ-009 Port d_orig  output  1  decoded, de-stuffed data bit.
REQ-010 Port bit_valid  output  1  one-cycle pulse, d_orig holds a payload bit.
REQ-011 Port eop  output  1  one-cycle pulse, EOP_LEN consecutive SE0 samples detected.
REQ-012 Port err  output  1  sticky error flag: stuff violation or SE1 seen; cleared by EOP or reset.

Function
REQ-013 Line state per strobe: J = (d_plus==IDLE_LEVEL, d_minus!=d_plus); K = opposite differential; SE0 = both 0; SE1 = both 1.
REQ-014 Only cycles with shift_enable=1 change internal state; other cycles hold all state, and bit_valid/eop are 0.
REQ-015 All outputs are registered; response to a strobe appears on the cycle after the strobe edge (latency 1 clk).
REQ-016 On a J/K strobe: decoded = 1 if d_plus equals stored prev_level, else 0; prev_level <= d_plus.
REQ-017 ones_cnt (width clog2(STUFF_LEN+1)) increments on decoded 1 and clears on decoded 0, never wraps.
REQ-018 decoded 0 with ones_cnt==STUFF_LEN is a stuff bit: bit_valid stays 0, ones_cnt <= 0, d_orig unchanged.
REQ-019 decoded 1 with ones_cnt==STUFF_LEN is a stuff violation: err <= 1, state -> ERR, ones_cnt <= 0, bit_valid 0.
REQ-020 Otherwise, in state RUN, a J/K strobe gives d_orig <= decoded and bit_valid <= 1.
REQ-021 State machine states are RUN (decode active) and ERR (decoding suppressed, bit_valid forced 0, NRZI history and eop detection still tracked).
REQ-022 SE0 strobe: eop_cnt increments, no bit emitted, prev_level and ones_cnt unchanged.
REQ-023 When eop_cnt reaches EOP_LEN: eop <= 1 for one cycle, eop_cnt <= 0, prev_level <= IDLE_LEVEL, ones_cnt <= 0, err <= 0, state -> RUN.
REQ-024 A J/K strobe with 0 < eop_cnt < EOP_LEN clears eop_cnt and is then decoded normally.
REQ-025 SE1 strobe: err <= 1, state -> ERR, eop_cnt <= 0, prev_level unchanged, no bit emitted.
REQ-026 An EOP completing in the same strobe that would set err resolves to err=0 and state RUN (EOP wins).

Reset
REQ-027 rst=1 asynchronously forces d_orig=0, bit_valid=0, eop=0, err=0, prev_level=IDLE_LEVEL, ones_cnt=0, eop_cnt=0, state=RUN.
REQ-028 rst overrides a concurrent shift_enable; the first strobe after rst deasserts is decoded against IDLE_LEVEL.
REQ-029 rst asserted mid-packet discards all partial stuffing and eop count; no eop pulse is generated.

Structure
REQ-030 Shared package usb_rx_pkg holds the line-state enum (LS_J, LS_K, LS_SE0, LS_SE1), the state enum (RUN, ERR) and the default STUFF_LEN/EOP_LEN constants.
REQ-031 Single module, no sub-module; line classification is combinational inside nrzi_destuff.

Verification
REQ-032 Reset then one J strobe -> d_orig=1, bit_valid=1 one cycle later; during rst all outputs 0.
REQ-033 Line sequence J,K,K,J (IDLE_LEVEL=1) -> decoded 1,0,1,0, each with bit_valid pulse.
REQ-034 STUFF_LEN=6: six J strobes then one K -> six bit_valid pulses with d_orig=1, the K produces no pulse, ones_cnt 0.
REQ-035 Seven J strobes -> six valid 1s, err=1 after seventh, later J/K strobes give no bit_valid until EOP.
REQ-036 SE0,SE0,J with EOP_LEN=2 -> eop pulse after second SE0, err cleared, J decodes as 1; SE0,J,SE0 -> no eop.
REQ-037 Strobe with d_plus=d_minus=1 -> err=1, no bit_valid; assert rst mid-stream -> err=0, state RUN immediately.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared USB receive-path types: line states, the destuffer state machine
// encoding, default framing constants and the line classifier.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2,
    LS_SE1 = 2'd3
  } line_state_t;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } rx_state_t;

  localparam int DEFAULT_STUFF_LEN = 6;
  localparam int DEFAULT_EOP_LEN   = 2;

  // Single-ended zero/one first; otherwise the differential pair is decided
  // by whether D+ sits at the idle (J) level.
  function automatic line_state_t classify_line(input logic dp,
                                                input logic dm,
                                                input logic idle_level);
    line_state_t ls;
    if (!dp && !dm)             ls = LS_SE0;
    else if (dp && dm)          ls = LS_SE1;
    else if (dp == idle_level)  ls = LS_J;
    else                        ls = LS_K;
    return ls;
  endfunction

endpackage

// File: rtl/nrzi_destuff.sv
// NRZI decoder with bit de-stuffing, SE0 end-of-packet detection and a
// sticky framing error flag. Everything advances only on shift_enable.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | decoding active, payload bits emitted on bit_valid
// ERR   | stuff violation or SE1 seen; bits suppressed until the next EOP,
//       | NRZI history and SE0 counting still follow the line
module nrzi_destuff #(
  parameter int   STUFF_LEN  = usb_rx_pkg::DEFAULT_STUFF_LEN,  // 2..15
  parameter int   EOP_LEN    = usb_rx_pkg::DEFAULT_EOP_LEN,    // 1..7
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus,
  input  logic d_minus,
  input  logic shift_enable,
  output logic d_orig,
  output logic bit_valid,
  output logic eop,
  output logic err
);

  import usb_rx_pkg::*;

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int EW = $clog2(EOP_LEN + 1);

  localparam logic [OW-1:0] STUFF_TC = OW'(STUFF_LEN);
  localparam logic [EW-1:0] EOP_TC   = EW'(EOP_LEN);

  rx_state_t     state;
  logic          prev_level;
  logic [OW-1:0] ones_cnt;
  logic [EW-1:0] eop_cnt;

  line_state_t   line_state;
  logic          decoded;
  logic [EW-1:0] eop_next;

  // Classify the line and form the NRZI-decoded bit for this sample.
  // eop_cnt is always below EOP_LEN, so the increment cannot overflow.
  always_comb begin
    line_state = classify_line(d_plus, d_minus, IDLE_LEVEL);
    decoded    = (d_plus == prev_level);
    eop_next   = eop_cnt + EW'(1);
  end

  // Decode/destuff state machine; all outputs registered, pulses last one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      prev_level <= IDLE_LEVEL;
      ones_cnt   <= '0;
      eop_cnt    <= '0;
      d_orig     <= 1'b0;
      bit_valid  <= 1'b0;
      eop        <= 1'b0;
      err        <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      eop       <= 1'b0;
      if (shift_enable) begin
        unique case (line_state)
          LS_SE0: begin
            // Completed EOP re-arms the receiver and clears any error.
            if (eop_next == EOP_TC) begin
              eop        <= 1'b1;
              eop_cnt    <= '0;
              prev_level <= IDLE_LEVEL;
              ones_cnt   <= '0;
              err        <= 1'b0;
              state      <= RUN;
            end else begin
              eop_cnt <= eop_next;
            end
          end
          LS_SE1: begin
            err     <= 1'b1;
            state   <= ERR;
            eop_cnt <= '0;
          end
          default: begin
            // J or K: any partial SE0 run is abandoned, then decode.
            eop_cnt    <= '0;
            prev_level <= d_plus;
            if (ones_cnt == STUFF_TC) begin
              ones_cnt <= '0;
              if (decoded) begin
                err   <= 1'b1;
                state <= ERR;
              end
            end else begin
              ones_cnt <= decoded ? ones_cnt + OW'(1) : '0;
              if (state == RUN) begin
                d_orig    <= decoded;
                bit_valid <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrzi_destuff.sv
module tb_nrzi_destuff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_plus = 1'b1;
  logic d_minus = 1'b0;
  logic shift_enable = 1'b0;
  logic d_orig, bit_valid, eop, err;

  int total = 0;
  int bad = 0;

  nrzi_destuff #(.STUFF_LEN(6), .EOP_LEN(2), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .d_plus(d_plus),
    .d_minus(d_minus),
    .shift_enable(shift_enable),
    .d_orig(d_orig),
    .bit_valid(bit_valid),
    .eop(eop),
    .err(err)
  );

  always #5 clk = ~clk;

  // One strobe; outputs are observable 1 time unit after its edge.
  task automatic strobe(input logic dp, input logic dm);
    @(negedge clk);
    d_plus = dp;
    d_minus = dm;
    shift_enable = 1'b1;
    @(posedge clk);
    #1;
    shift_enable = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (bit_valid !== 1'b0) begin bad++; $display("FAIL reset_bv got=%b exp=0", bit_valid); end
    total++; if (d_orig !== 1'b0) begin bad++; $display("FAIL reset_dorig got=%b exp=0", d_orig); end
    total++; if (eop !== 1'b0) begin bad++; $display("FAIL reset_eop got=%b exp=0", eop); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
    strobe(1'b1, 1'b0);
    total++; if (bit_valid !== 1'b1 || d_orig !== 1'b1) begin bad++; $display("FAIL first_j got bv=%b d=%b exp bv=1 d=1", bit_valid, d_orig); end
    @(posedge clk); #1;
    total++; if (bit_valid !== 1'b0) begin bad++; $display("FAIL bv_pulse_width got=%b exp=0", bit_valid); end
  endtask

  task automatic test_nrzi();
    logic [3:0] dp_seq;
    logic [3:0] exp_seq;
    apply_reset();
    dp_seq  = 4'b1001;  // J,K,K,J issued MSB first
    exp_seq = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      strobe(dp_seq[i], ~dp_seq[i]);
      total++;
      if (bit_valid !== 1'b1 || d_orig !== exp_seq[i]) begin
        bad++; $display("FAIL nrzi_bit%0d got bv=%b d=%b exp bv=1 d=%b", 3 - i, bit_valid, d_orig, exp_seq[i]);
      end
    end
  endtask

  task automatic test_stuff();
    int nvalid;
    apply_reset();
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      strobe(1'b1, 1'b0);
      if (bit_valid === 1'b1 && d_orig === 1'b1) nvalid++;
    end
    total++; if (nvalid != 6) begin bad++; $display("FAIL stuff_ones got=%0d exp=6", nvalid); end
    strobe(1'b0, 1'b1);
    total++; if (bit_valid !== 1'b0 || d_orig !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL stuff_bit got bv=%b d=%b err=%b exp bv=0 d=1 err=0", bit_valid, d_orig, err); end
    // Six more decoded 1s (K held) are legal only if the run counter cleared.
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      strobe(1'b0, 1'b1);
      if (bit_valid === 1'b1 && d_orig === 1'b1 && err === 1'b0) nvalid++;
    end
    total++; if (nvalid != 6) begin bad++; $display("FAIL stuff_cnt_clear got=%0d exp=6", nvalid); end
  endtask

  task automatic test_violation();
    int nvalid;
    apply_reset();
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      strobe(1'b1, 1'b0);
      if (bit_valid === 1'b1) nvalid++;
    end
    strobe(1'b1, 1'b0);
    total++; if (nvalid != 6 || bit_valid !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL violation got n=%0d bv=%b err=%b exp n=6 bv=0 err=1", nvalid, bit_valid, err); end
    nvalid = 0;
    strobe(1'b1, 1'b0); if (bit_valid === 1'b1) nvalid++;
    strobe(1'b0, 1'b1); if (bit_valid === 1'b1) nvalid++;
    strobe(1'b0, 1'b1); if (bit_valid === 1'b1) nvalid++;
    total++; if (nvalid != 0 || err !== 1'b1) begin bad++; $display("FAIL err_suppress got n=%0d err=%b exp n=0 err=1", nvalid, err); end
    strobe(1'b0, 1'b0);
    strobe(1'b0, 1'b0);
    total++; if (eop !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL err_eop_clear got eop=%b err=%b exp eop=1 err=0", eop, err); end
    strobe(1'b1, 1'b0);
    total++; if (bit_valid !== 1'b1 || d_orig !== 1'b1) begin bad++; $display("FAIL after_eop_j got bv=%b d=%b exp bv=1 d=1", bit_valid, d_orig); end
  endtask

  task automatic test_eop();
    int neop;
    apply_reset();
    strobe(1'b0, 1'b0);
    total++; if (eop !== 1'b0 || bit_valid !== 1'b0) begin bad++; $display("FAIL se0_first got eop=%b bv=%b exp 0 0", eop, bit_valid); end
    strobe(1'b0, 1'b0);
    total++; if (eop !== 1'b1) begin bad++; $display("FAIL se0_second got eop=%b exp=1", eop); end
    @(posedge clk); #1;
    total++; if (eop !== 1'b0) begin bad++; $display("FAIL eop_pulse_width got=%b exp=0", eop); end
    // A K before the EOP moves NRZI history; the EOP must restore idle level.
    apply_reset();
    strobe(1'b0, 1'b1);
    strobe(1'b0, 1'b0);
    strobe(1'b0, 1'b0);
    strobe(1'b1, 1'b0);
    total++; if (bit_valid !== 1'b1 || d_orig !== 1'b1) begin bad++; $display("FAIL eop_idle_restore got bv=%b d=%b exp bv=1 d=1", bit_valid, d_orig); end
    neop = 0;
    strobe(1'b0, 1'b0); if (eop === 1'b1) neop++;
    strobe(1'b1, 1'b0); if (eop === 1'b1) neop++;
    total++; if (bit_valid !== 1'b1 || d_orig !== 1'b1) begin bad++; $display("FAIL se0_j_decode got bv=%b d=%b exp bv=1 d=1", bit_valid, d_orig); end
    strobe(1'b0, 1'b0); if (eop === 1'b1) neop++;
    strobe(1'b0, 1'b1); if (eop === 1'b1) neop++;
    // SE1 also abandons a partial SE0 run.
    strobe(1'b0, 1'b0); if (eop === 1'b1) neop++;
    strobe(1'b1, 1'b1); if (eop === 1'b1) neop++;
    strobe(1'b0, 1'b0); if (eop === 1'b1) neop++;
    total++; if (neop != 0) begin bad++; $display("FAIL broken_se0 got eops=%0d exp=0", neop); end
  endtask

  task automatic test_se1_and_reset();
    apply_reset();
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b1);
    total++; if (err !== 1'b1 || bit_valid !== 1'b0) begin bad++; $display("FAIL se1 got err=%b bv=%b exp err=1 bv=0", err, bit_valid); end
    strobe(1'b1, 1'b0);
    total++; if (bit_valid !== 1'b0) begin bad++; $display("FAIL se1_suppress got bv=%b exp=0", bit_valid); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total++; if (err !== 1'b0 || d_orig !== 1'b0) begin bad++; $display("FAIL async_rst got err=%b d=%b exp 0 0", err, d_orig); end
    // Strobe held during reset must be ignored.
    @(negedge clk);
    d_plus = 1'b0; d_minus = 1'b1; shift_enable = 1'b1;
    @(negedge clk);
    shift_enable = 1'b0;
    total++; if (bit_valid !== 1'b0) begin bad++; $display("FAIL rst_vs_strobe got bv=%b exp=0", bit_valid); end
    rst = 1'b0;
    strobe(1'b1, 1'b0);
    total++; if (bit_valid !== 1'b1 || d_orig !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL post_rst_j got bv=%b d=%b err=%b exp 1 1 0", bit_valid, d_orig, err); end
  endtask

  task automatic test_hold();
    int nact;
    apply_reset();
    strobe(1'b0, 1'b1);
    nact = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d_plus = i[0]; d_minus = ~i[0];
      @(posedge clk); #1;
      if (bit_valid !== 1'b0 || eop !== 1'b0) nact++;
    end
    total++; if (nact != 0) begin bad++; $display("FAIL idle_pulses got=%0d exp=0", nact); end
    strobe(1'b0, 1'b1);
    total++; if (bit_valid !== 1'b1 || d_orig !== 1'b1) begin bad++; $display("FAIL idle_hold got bv=%b d=%b exp bv=1 d=1", bit_valid, d_orig); end
  endtask

  initial begin
    test_reset();
    test_nrzi();
    test_stuff();
    test_violation();
    test_eop();
    test_se1_and_reset();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
